monitor_event_arbiter: RTL

Round-robin arbiter that shares the single join/leave event port of the active IoT devices `monitor` counter between several requesters (gateways). It serialises device on/off events into one-cycle `change`/`on_off` pulses, acknowledges each requester, and keeps a shadow copy of the device count. It sits directly in front of `monitor`, whose `change` and `on_off` inputs it drives.

---
 rtl/monitor_event_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/monitor_event_arbiter.sv
// Round-robin arbiter serialising requester on/off events onto the monitor change/on_off port.
// Optional MONITOR_ARB_SAT_EN: reject events that would overflow/underflow the shadow count.
module monitor_event_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             arb_en_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] dir_i,
  output logic [N_REQ-1:0] ack_o,
  output logic [N_REQ-1:0] rej_o,
  output logic             change_o,
  output logic             on_off_o,
  output logic [CNT_W-1:0] shadow_cnt_o,
  output logic             busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;

  logic [PTR_W-1:0] win;
  logic [N_REQ-1:0] grant_oh;
  logic             grant;
  logic             reject;

  // Search starts one past the last winner, so every requester waits at most N_REQ-1 grants.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    win   = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign grant    = (state_q == IDLE) && arb_en_i && (|req_i);
  assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win;

`ifdef MONITOR_ARB_SAT_EN
  logic [N_REQ-1:0] rej_q;

  function automatic logic sat_reject(input logic up, input logic [CNT_W-1:0] cnt);
    return up ? (&cnt) : (cnt == '0);
  endfunction

  assign reject = sat_reject(dir_i[win], shadow_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      rej_q <= '0;
    else
      rej_q <= (grant && reject) ? grant_oh : '0;
  end

  assign rej_o = rej_q;
`else
  assign reject = 1'b0;
  assign rej_o  = '0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    change_d = 1'b0;
    on_off_d = 1'b0;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = ISSUE;
          ptr_d    = win;
          ack_d    = grant_oh;
          change_d = !reject;
          on_off_d = !reject && dir_i[win];
        end
      end
      ISSUE: begin
        // Shadow moves on the same edge the monitor consumes the change pulse.
        state_d = IDLE;
        if (change_q)
          shadow_d = on_off_q ? shadow_q + CNT_W'(1) : shadow_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(N_REQ - 1);
      ack_q    <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      change_q <= change_d;
      on_off_q <= on_off_d;
      shadow_q <= shadow_d;
    end
  end

  assign ack_o        = ack_q;
  assign change_o     = change_q;
  assign on_off_o     = on_off_q;
  assign shadow_cnt_o = shadow_q;
  assign busy_o       = (state_q == ISSUE);

endmodule
